// File: rtl/hamming_enc_arbiter_if.sv
// rtl/hamming_enc_arbiter_if.sv - requester byte ports and shared codeword output of the Hamming encode arbiter
// master drives requests and downstream ready; slave is the arbiter.
interface hamming_enc_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ*8-1:0] req_data;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 out_valid;
   logic                 out_ready;
   logic [11:0]          out_codeword;
   logic [ID_W-1:0]      out_id;

   modport master (
      output req_valid,
      output req_data,
      output out_ready,
      input  req_ready,
      input  out_valid,
      input  out_codeword,
      input  out_id
   );

   modport slave (
      input  req_valid,
      input  req_data,
      input  out_ready,
      output req_ready,
      output out_valid,
      output out_codeword,
      output out_id
   );
endinterface

// File: rtl/hamming_enc_arbiter.sv
// rtl/hamming_enc_arbiter.sv - round-robin arbitration of NUM_REQ byte requesters into one Hamming(12,8) encoder
// One registered output slot; it refills in the same cycle it drains for 1 beat/cycle.
module hamming_enc_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   hamming_enc_arbiter_if.slave   bus
);

   function automatic logic [11:0] encode(input logic [7:0] d);
      logic p0, p1, p2, p3;
      p0 = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
      p1 = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
      p2 = d[1] ^ d[2] ^ d[3] ^ d[7];
      p3 = d[4] ^ d[5] ^ d[6] ^ d[7];
      return {p3, p2, p1, p0, d};
   endfunction

   logic                 load_en;
   logic                 grant_found;
   logic [ID_W-1:0]      grant;
   logic [ID_W-1:0]      ptr;
   logic [ID_W-1:0]      ptr_next;
   logic [NUM_REQ-1:0]   req_ready_int;
   logic                 accept;
   logic [7:0]           grant_data;
   logic                 out_valid_q;
   logic [11:0]          out_codeword_q;
   logic [ID_W-1:0]      out_id_q;

   assign load_en = !out_valid_q || bus.out_ready;

   // Search starts at ptr and wraps modulo NUM_REQ; the first valid requester wins.
   always_comb begin
      grant       = '0;
      grant_found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!grant_found && bus.req_valid[(int'(ptr) + k) % NUM_REQ]) begin
            grant_found = 1'b1;
            grant       = ID_W'((int'(ptr) + k) % NUM_REQ);
         end
      end
   end

   always_comb begin
      req_ready_int = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready_int[i] = rst_n && load_en && grant_found &&
                            (grant == ID_W'(i)) && bus.req_valid[i];
      end
   end

   assign bus.req_ready = req_ready_int;
   assign accept        = |req_ready_int;
   assign grant_data    = bus.req_data[int'(grant)*8 +: 8];
   assign ptr_next      = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q    <= 1'b0;
         out_codeword_q <= '0;
         out_id_q       <= '0;
         ptr            <= '0;
      end else if (accept) begin
         out_valid_q    <= 1'b1;
         out_codeword_q <= encode(grant_data);
         out_id_q       <= grant;
         ptr            <= ptr_next;
      end else if (load_en) begin
         out_valid_q    <= 1'b0;
      end
   end

   assign bus.out_valid    = out_valid_q;
   assign bus.out_codeword = out_codeword_q;
   assign bus.out_id       = out_id_q;

endmodule

// File: tb/tb_hamming_enc_arbiter.sv
// tb/tb_hamming_enc_arbiter.sv - scoreboard bench for hamming_enc_arbiter with directed vectors
module tb_hamming_enc_arbiter;
   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hamming_enc_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

   hamming_enc_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int          total = 0;
   int          bad   = 0;
   logic [13:0] exp_q[$];
   logic [13:0] mon_exp;
   logic [11:0] rr_cw [4] = '{12'h910, 12'hA11, 12'hC12, 12'hF13};
   logic [7:0]  enc_bytes [4] = '{8'h00, 8'hAA, 8'hFF, 8'hF0};
   logic [11:0] enc_cw [4]    = '{12'h000, 12'h4AA, 12'h3FF, 12'h4F0};

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int id, input logic [11:0] cw);
      exp_q.push_back({2'(id), cw});
   endtask

   task automatic set_byte(input int i, input logic [7:0] b);
      bus.req_data[i*8 +: 8] = b;
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat: got id=%0d cw=0x%03h expected none", bus.out_id, bus.out_codeword);
         end else begin
            mon_exp = exp_q.pop_front();
            check("beat_id", 32'(bus.out_id), 32'(mon_exp[13:12]));
            check("beat_cw", 32'(bus.out_codeword), 32'(mon_exp[11:0]));
         end
      end
   end

   initial begin
      bus.req_valid = 4'b0001;
      bus.req_data  = '0;
      bus.out_ready = 1'b0;
      tick();
      tick();
      check("rst_req_ready", 32'(bus.req_ready), 32'h0);
      check("rst_out_valid", 32'(bus.out_valid), 32'h0);
      check("rst_codeword", 32'(bus.out_codeword), 32'h0);
      check("rst_id", 32'(bus.out_id), 32'h0);

      // single beat from requester 0
      rst_n         = 1'b1;
      bus.out_ready = 1'b1;
      set_byte(0, 8'h01);
      #1;
      check("single_req_ready", 32'(bus.req_ready), 32'h1);
      push(0, 12'h301);
      tick();
      bus.req_valid = '0;
      check("single_out_valid", 32'(bus.out_valid), 32'h1);
      tick();
      check("single_drained", 32'(bus.out_valid), 32'h0);

      // encoding values through requester 2, back to back
      bus.req_valid = 4'b0100;
      for (int k = 0; k < 4; k++) begin
         set_byte(2, enc_bytes[k]);
         #1;
         check("enc_req_ready", 32'(bus.req_ready), 32'h4);
         push(2, enc_cw[k]);
         tick();
         check("enc_out_valid", 32'(bus.out_valid), 32'h1);
      end
      bus.req_valid = '0;
      tick();
      check("enc_drained", 32'(bus.out_valid), 32'h0);

      // round robin, pointer is 3 after requester 2's last grant
      for (int i = 0; i < 4; i++) set_byte(i, 8'(8'h10 + i));
      bus.req_valid = 4'b1111;
      #1;
      for (int k = 0; k < 8; k++) begin
         check("rr_grant", 32'(bus.req_ready), 32'(1 << ((3 + k) % 4)));
         push((3 + k) % 4, rr_cw[(3 + k) % 4]);
         tick();
      end

      // backpressure with slot holding id 2 / 0xC12
      bus.out_ready = 1'b0;
      bus.req_valid = 4'b0010;
      set_byte(1, 8'h5B);
      #1;
      for (int c = 0; c < 5; c++) begin
         check("stall_req_ready", 32'(bus.req_ready), 32'h0);
         check("stall_valid", 32'(bus.out_valid), 32'h1);
         check("stall_codeword", 32'(bus.out_codeword), 32'hC12);
         check("stall_id", 32'(bus.out_id), 32'h2);
         tick();
      end
      bus.out_ready = 1'b1;
      #1;
      check("release_req_ready", 32'(bus.req_ready), 32'h2);
      push(1, 12'h35B);
      tick();
      bus.req_valid = '0;
      check("release_refill", 32'(bus.out_valid), 32'h1);
      tick();
      check("release_drained", 32'(bus.out_valid), 32'h0);

      // pointer skip: move pointer to 1, then only requesters 0 and 3 valid
      bus.req_valid = 4'b0001;
      set_byte(0, 8'h80);
      #1;
      check("skip_setup_grant", 32'(bus.req_ready), 32'h1);
      push(0, 12'hC80);
      tick();
      bus.req_valid = 4'b1001;
      set_byte(0, 8'h02);
      set_byte(3, 8'h40);
      #1;
      check("skip_grant3", 32'(bus.req_ready), 32'h8);
      push(3, 12'hB40);
      tick();
      check("skip_grant0", 32'(bus.req_ready), 32'h1);
      push(0, 12'h502);
      tick();
      check("skip_ptr1", 32'(bus.req_ready), 32'h8);
      bus.req_valid = '0;
      tick();

      // async reset during a stall
      bus.out_ready = 1'b0;
      bus.req_valid = 4'b0010;
      set_byte(1, 8'hFF);
      #1;
      check("areset_load", 32'(bus.req_ready), 32'h2);
      tick();
      bus.req_valid = 4'b1111;
      check("areset_held_cw", 32'(bus.out_codeword), 32'h3FF);
      check("areset_held_id", 32'(bus.out_id), 32'h1);
      tick();
      check("areset_stall_ready", 32'(bus.req_ready), 32'h0);
      #2;
      rst_n = 1'b0;
      #1;
      check("areset_valid", 32'(bus.out_valid), 32'h0);
      check("areset_codeword", 32'(bus.out_codeword), 32'h0);
      check("areset_id", 32'(bus.out_id), 32'h0);
      check("areset_req_ready", 32'(bus.req_ready), 32'h0);
      tick();
      rst_n         = 1'b1;
      bus.out_ready = 1'b1;
      set_byte(0, 8'h10);
      #1;
      check("areset_restart", 32'(bus.req_ready), 32'h1);
      push(0, 12'h910);
      tick();
      bus.req_valid = '0;
      tick();
      tick();
      check("queue_empty", 32'(exp_q.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
